// File: rtl/cpu_pkg.sv
// Shared CPU definitions: reset/trap vectors, NOP encoding, next-PC select codes.
package cpu_pkg;

  localparam logic [31:0] RESET_PC = 32'h8000_0000;
  localparam logic [31:0] IRQ_VEC  = 32'h8000_0004;
  localparam logic [31:0] EXC_VEC  = 32'h8000_0008;
  localparam logic [31:0] NOP      = 32'h0000_0000;

  typedef enum logic [2:0] {
    SEL_SEQ,
    SEL_HOLD,
    SEL_JUMP,
    SEL_JR,
    SEL_BR,
    SEL_IRQ,
    SEL_EXC
  } pc_sel_e;

  // Sequential successor; bit 31 is the kernel-mode flag and never takes a carry.
  function automatic logic [31:0] pc_plus4(input logic [31:0] p);
    return {p[31], p[30:0] + 31'd4};
  endfunction

endpackage

// File: rtl/if_fetch_ctrl_if.sv
// Instruction ROM bus between the fetch controller (master) and the ROM (slave).
interface if_fetch_ctrl_if;

  logic [31:0] rom_addr;
  logic [31:0] rom_data;

  modport master (output rom_addr, input rom_data);
  modport slave  (input rom_addr, output rom_data);

endinterface

// File: rtl/if_fetch_ctrl_next_pc_sel.sv
// Combinational next-PC priority encoder: exc > branch > jr > jump > irq > stall > seq.
module next_pc_sel #(
  parameter logic [31:0] IRQ_VEC = cpu_pkg::IRQ_VEC,
  parameter logic [31:0] EXC_VEC = cpu_pkg::EXC_VEC
) (
  input  logic [31:0]      pc,
  input  logic             stall,
  input  logic             jump,
  input  logic [25:0]      jump_index,
  input  logic             jr,
  input  logic [31:0]      jr_target,
  input  logic             branch_taken,
  input  logic [31:0]      branch_target,
  input  logic             ctrl_pending,
  input  logic             exc,
  input  logic             irq,
  output cpu_pkg::pc_sel_e sel,
  output logic [31:0]      next_pc,
  output logic [31:0]      pc4,
  output logic             irq_take
);
  import cpu_pkg::*;

  assign pc4 = pc_plus4(pc);

  // Interrupts are only taken on a quiet user-mode cycle, so the discarded
  // instruction at pc can be safely re-fetched from epc.
  assign irq_take = irq & ~pc[31] & ~ctrl_pending & ~stall & ~exc
                  & ~branch_taken & ~jump & ~jr;

  always_comb begin
    sel     = SEL_SEQ;
    next_pc = pc4;
    if (exc) begin
      sel     = SEL_EXC;
      next_pc = EXC_VEC;
    end else if (branch_taken) begin
      sel     = SEL_BR;
      next_pc = branch_target;
    end else if (jr) begin
      sel     = SEL_JR;
      next_pc = jr_target;
    end else if (jump) begin
      sel     = SEL_JUMP;
      next_pc = {pc4[31:28], jump_index, 2'b00};
    end else if (irq_take) begin
      sel     = SEL_IRQ;
      next_pc = IRQ_VEC;
    end else if (stall) begin
      sel     = SEL_HOLD;
      next_pc = pc;
    end
  end

endmodule

// File: rtl/if_fetch_ctrl.sv
// Instruction-fetch controller: PC register, ROM addressing, IF/ID stage, EPC capture.
module if_fetch_ctrl #(
  parameter logic [31:0] RESET_PC = cpu_pkg::RESET_PC,
  parameter logic [31:0] IRQ_VEC  = cpu_pkg::IRQ_VEC,
  parameter logic [31:0] EXC_VEC  = cpu_pkg::EXC_VEC
) (
  input  logic                   clk,
  input  logic                   reset,
  if_fetch_ctrl_if.master        rom,
  input  logic                   stall,
  input  logic                   jump,
  input  logic [25:0]            jump_index,
  input  logic                   jr,
  input  logic [31:0]            jr_target,
  input  logic                   branch_taken,
  input  logic [31:0]            branch_target,
  input  logic                   ctrl_pending,
  input  logic                   exc,
  input  logic [31:0]            exc_pc,
  input  logic                   irq,
  output logic [31:0]            pc,
  output logic [31:0]            if_id_instr,
  output logic [31:0]            if_id_pc4,
  output logic                   if_id_valid,
  output logic                   flush_if_id,
  output logic [31:0]            epc,
  output logic                   epc_we,
  output logic                   irq_ack
);
  import cpu_pkg::*;

  pc_sel_e     sel_p0;
  logic [31:0] next_pc_p0;
  logic [31:0] pc4_p0;
  logic        irq_take_p0;

  logic [31:0] pc_p0;
  logic [31:0] instr_p1;
  logic [31:0] pc4_p1;
  logic        vld_p1;
  logic [31:0] epc_p1;
  logic        epc_we_p1;
  logic        irq_ack_p1;

  next_pc_sel #(
    .IRQ_VEC (IRQ_VEC),
    .EXC_VEC (EXC_VEC)
  ) u_next_pc_sel (
    .pc            (pc_p0),
    .stall         (stall),
    .jump          (jump),
    .jump_index    (jump_index),
    .jr            (jr),
    .jr_target     (jr_target),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .ctrl_pending  (ctrl_pending),
    .exc           (exc),
    .irq           (irq),
    .sel           (sel_p0),
    .next_pc       (next_pc_p0),
    .pc4           (pc4_p0),
    .irq_take      (irq_take_p0)
  );

  assign flush_if_id = exc | branch_taken | jr | jump | irq_take_p0;

  // IF stage: PC register drives the ROM address directly
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) pc_p0 <= RESET_PC;
    else        pc_p0 <= next_pc_p0;
  end

  assign rom.rom_addr = pc_p0;
  assign pc           = pc_p0;

  // IF/ID boundary: a redirect squashes the fetched word even while stalled
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      instr_p1 <= NOP;
      pc4_p1   <= 32'h0;
      vld_p1   <= 1'b0;
    end else if (flush_if_id) begin
      instr_p1 <= NOP;
      pc4_p1   <= 32'h0;
      vld_p1   <= 1'b0;
    end else if (!stall) begin
      instr_p1 <= rom.rom_data;
      pc4_p1   <= pc4_p0;
      vld_p1   <= 1'b1;
    end
  end

  // Trap bookkeeping: epc holds its value between traps, the strobes are one-cycle
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      epc_p1     <= 32'h0;
      epc_we_p1  <= 1'b0;
      irq_ack_p1 <= 1'b0;
    end else begin
      epc_we_p1  <= 1'b0;
      irq_ack_p1 <= 1'b0;
      if (sel_p0 == SEL_EXC) begin
        epc_p1    <= exc_pc + 32'd4;
        epc_we_p1 <= 1'b1;
      end else if (sel_p0 == SEL_IRQ) begin
        epc_p1     <= pc_p0;
        epc_we_p1  <= 1'b1;
        irq_ack_p1 <= 1'b1;
      end
    end
  end

  assign if_id_instr = instr_p1;
  assign if_id_pc4   = pc4_p1;
  assign if_id_valid = vld_p1;
  assign epc         = epc_p1;
  assign epc_we      = epc_we_p1;
  assign irq_ack     = irq_ack_p1;

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// Directed bench for if_fetch_ctrl with hand-computed expectations and a ROM model.
module tb_if_fetch_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall, jump, jr, branch_taken, ctrl_pending, exc, irq;
  logic [25:0] jump_index;
  logic [31:0] jr_target, branch_target, exc_pc;
  logic [31:0] pc, if_id_instr, if_id_pc4, epc;
  logic        if_id_valid, flush_if_id, epc_we, irq_ack;

  int total = 0;
  int bad   = 0;

  if_fetch_ctrl_if rom_bus ();

  function automatic logic [31:0] rom_fn(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h0F0F_0F0F;
  endfunction

  assign rom_bus.rom_data = rom_fn(rom_bus.rom_addr);

  if_fetch_ctrl dut (
    .clk           (clk),
    .reset         (reset),
    .rom           (rom_bus.master),
    .stall         (stall),
    .jump          (jump),
    .jump_index    (jump_index),
    .jr            (jr),
    .jr_target     (jr_target),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .ctrl_pending  (ctrl_pending),
    .exc           (exc),
    .exc_pc        (exc_pc),
    .irq           (irq),
    .pc            (pc),
    .if_id_instr   (if_id_instr),
    .if_id_pc4     (if_id_pc4),
    .if_id_valid   (if_id_valid),
    .flush_if_id   (flush_if_id),
    .epc           (epc),
    .epc_we        (epc_we),
    .irq_ack       (irq_ack)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b0;
    stall = 0; jump = 0; jr = 0; branch_taken = 0; ctrl_pending = 0; exc = 0; irq = 0;
    jump_index = '0; jr_target = '0; branch_target = '0; exc_pc = '0;

    #12;
    check("rst_pc", pc, 32'h8000_0000);
    check("rst_valid", {31'd0, if_id_valid}, 32'd0);
    check("rst_instr", if_id_instr, 32'd0);
    check("rst_pc4", if_id_pc4, 32'd0);
    check("rst_epc", epc, 32'd0);
    check("rst_epc_we", {31'd0, epc_we}, 32'd0);
    check("rst_irq_ack", {31'd0, irq_ack}, 32'd0);

    reset = 1'b1;
    #1;
    check("rel_rom_addr", rom_bus.rom_addr, 32'h8000_0000);
    step();
    check("rel_valid", {31'd0, if_id_valid}, 32'd1);
    check("rel_pc4", if_id_pc4, 32'h8000_0004);
    check("rel_instr", if_id_instr, rom_fn(32'h8000_0000));
    check("rel_pc", pc, 32'h8000_0004);

    reset = 1'b0;
    #1;
    check("rerst_pc", pc, 32'h8000_0000);
    reset = 1'b1;

    // jump from the reset PC
    jump = 1; jump_index = 26'h2D;
    #1;
    check("jmp_flush", {31'd0, flush_if_id}, 32'd1);
    step();
    jump = 0;
    check("jmp_pc", pc, 32'h8000_00B4);
    check("jmp_valid", {31'd0, if_id_valid}, 32'd0);
    check("jmp_instr", if_id_instr, 32'd0);

    // user-mode wrap stays in user mode
    jr = 1; jr_target = 32'h7FFF_FFFC;
    step();
    jr = 0;
    check("wrapu_pc0", pc, 32'h7FFF_FFFC);
    step();
    check("wrapu_pc1", pc, 32'h0000_0000);
    check("wrapu_instr", if_id_instr, rom_fn(32'h7FFF_FFFC));
    // kernel-mode wrap stays in kernel mode
    jr = 1; jr_target = 32'hFFFF_FFFC;
    step();
    jr = 0;
    step();
    check("wrapk_pc", pc, 32'h8000_0000);
    check("wrapk_pc4", if_id_pc4, 32'h8000_0000);

    // interrupt from a quiet user-mode cycle
    jr = 1; jr_target = 32'h0000_0070;
    step();
    jr = 0;
    check("irq_at_pc", pc, 32'h0000_0070);
    irq = 1;
    #1;
    check("irq_flush", {31'd0, flush_if_id}, 32'd1);
    step();
    check("irq_pc", pc, 32'h8000_0004);
    check("irq_epc", epc, 32'h0000_0070);
    check("irq_epc_we", {31'd0, epc_we}, 32'd1);
    check("irq_ack1", {31'd0, irq_ack}, 32'd1);
    check("irq_valid", {31'd0, if_id_valid}, 32'd0);
    step();
    check("kmask_pc", pc, 32'h8000_0008);
    check("kmask_ack", {31'd0, irq_ack}, 32'd0);
    check("kmask_we", {31'd0, epc_we}, 32'd0);
    check("kmask_pc4", if_id_pc4, 32'h8000_0008);
    check("kmask_instr", if_id_instr, rom_fn(32'h8000_0004));
    irq = 0;

    // branch beats stall and irq
    jr = 1; jr_target = 32'h0000_0060;
    step();
    jr = 0;
    branch_taken = 1; branch_target = 32'h0000_0078; stall = 1; irq = 1;
    #1;
    check("br_flush", {31'd0, flush_if_id}, 32'd1);
    step();
    branch_taken = 0; stall = 0;
    check("br_pc", pc, 32'h0000_0078);
    check("br_valid", {31'd0, if_id_valid}, 32'd0);
    check("br_no_ack", {31'd0, irq_ack}, 32'd0);
    ctrl_pending = 1;
    #1;
    check("pend_flush", {31'd0, flush_if_id}, 32'd0);
    step();
    check("pend_pc", pc, 32'h0000_007C);
    check("pend_no_ack", {31'd0, irq_ack}, 32'd0);
    check("pend_instr", if_id_instr, rom_fn(32'h0000_0078));
    ctrl_pending = 0;

    // exception beats irq; irq taken after jr back to user code
    exc = 1; exc_pc = 32'h0000_0040;
    step();
    exc = 0;
    check("exc_pc", pc, 32'h8000_0008);
    check("exc_epc", epc, 32'h0000_0044);
    check("exc_we", {31'd0, epc_we}, 32'd1);
    check("exc_no_ack", {31'd0, irq_ack}, 32'd0);
    jr = 1; jr_target = 32'h0000_0044;
    step();
    jr = 0;
    check("ret_pc", pc, 32'h0000_0044);
    check("ret_we", {31'd0, epc_we}, 32'd0);
    step();
    irq = 0;
    check("late_irq_pc", pc, 32'h8000_0004);
    check("late_irq_ack", {31'd0, irq_ack}, 32'd1);
    check("late_irq_epc", epc, 32'h0000_0044);

    // stall holds PC and IF/ID, then async reset mid-stall
    step();
    check("pre_stall_pc", pc, 32'h8000_0008);
    stall = 1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall_pc", pc, 32'h8000_0008);
      check("stall_instr", if_id_instr, rom_fn(32'h8000_0004));
      check("stall_pc4", if_id_pc4, 32'h8000_0008);
      check("stall_valid", {31'd0, if_id_valid}, 32'd1);
    end
    #2;
    reset = 1'b0;
    #1;
    check("midrst_pc", pc, 32'h8000_0000);
    check("midrst_valid", {31'd0, if_id_valid}, 32'd0);
    check("midrst_epc", epc, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/if_fetch_ctrl.md
Name: if_fetch_ctrl

Overview:
Instruction-fetch controller for the pipelined CPU. Owns the PC, drives the instruction ROM address, and registers the IF/ID pipeline stage. Selects the next PC among sequential, jump, jr, branch, interrupt and exception vectors. Handles stall and flush, and maintains the kernel-mode bit in PC[31].

Parameters:
RESET_PC, 32'h8000_0000, PC loaded on reset; kernel mode, ROM word 0.
IRQ_VEC, 32'h8000_0004, interrupt handler entry (ROM word 1).
EXC_VEC, 32'h8000_0008, exception handler entry (ROM word 2).

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
rom_addr  out  32  to ROM addr; equals pc
rom_data  in  32  instruction from ROM, combinational on rom_addr
stall  in  1  hazard unit: hold PC and IF/ID
jump  in  1  ID-stage j/jal
jump_index  in  26  instr[25:0] of the ID-stage jump
jr  in  1  ID-stage jr/jalr
jr_target  in  32  forwarded rs value
branch_taken  in  1  EX-stage branch resolved taken
branch_target  in  32  EX-stage branch target
ctrl_pending  in  1  ID or EX holds an unresolved branch/jump
exc  in  1  exception raised (undefined instruction)
exc_pc  in  32  PC of the faulting instruction
irq  in  1  timer interrupt request, level
pc  out  32  current fetch PC
if_id_instr  out  32  registered instruction
if_id_pc4  out  32  registered PC+4, PC[31] preserved
if_id_valid  out  1  0 means bubble
flush_if_id  out  1  combinational; a redirect occurs this cycle
epc  out  32  return address for $26 writeback
epc_we  out  1  one-cycle pulse with epc
irq_ack  out  1  one-cycle pulse when the interrupt is taken

Behaviour:
- Reset (reset=0, async):
  - pc=RESET_PC.
  - if_id_instr=0 (nop), if_id_pc4=0, if_id_valid=0.
  - epc=0, epc_we=0, irq_ack=0.
- pc4 = {pc[31], pc[30:0]+4}. The kernel bit never carries in or out.
- irq_take = irq & ~pc[31] & ~ctrl_pending & ~stall & ~exc & ~branch_taken & ~jump & ~jr.
- Next-PC priority, highest first:
  1. exc -> EXC_VEC. epc=exc_pc+4, epc_we=1.
  2. branch_taken -> branch_target.
  3. jr -> jr_target. The only path that may clear PC[31].
  4. jump -> {pc4[31:28], jump_index, 2'b00}; bit 31 follows the current PC.
  5. irq_take -> IRQ_VEC. epc=pc, so the handler re-fetches the discarded instruction. epc_we=1, irq_ack=1.
  6. stall -> pc holds.
  7. otherwise -> pc4.
- flush_if_id = exc | branch_taken | jr | jump | irq_take.
- IF/ID register update:
  - On flush: instr=0, pc4=0, valid=0. Flush overrides stall.
  - Else if stall: hold all IF/ID fields.
  - Else: instr=rom_data, pc4=pc4, valid=1.
- Latency: one cycle from redirect input to rom_addr=target. The target instruction appears in IF/ID the following cycle.
- Kernel mode (pc[31]=1) masks irq entirely. It is re-enabled only after jr to a user address.
- Simultaneous exc and irq: exc wins; irq stays pending.
- irq held across the exception: it is taken after return once the other conditions hold.
- epc_we and irq_ack are registered pulses, high exactly one cycle after the decision edge.
- Reset mid-operation: all state returns to reset values immediately. No pending interrupt is remembered.
- Wrap: pc[30:0] overflow wraps silently within the current mode.

Decomposition:
- Shared package cpu_pkg:
  - RESET_PC, IRQ_VEC, EXC_VEC constants.
  - NOP encoding.
  - next-PC select enum {SEL_SEQ, SEL_HOLD, SEL_JUMP, SEL_JR, SEL_BR, SEL_IRQ, SEL_EXC}.
- One natural sub-module: next_pc_sel. Combinational priority encoder producing the select, next PC and irq_take.
- The PC and IF/ID registers stay in the top.

Test Plan:
- Reset release -> rom_addr=32'h8000_0000; after 1 cycle if_id_valid=1, if_id_pc4=32'h8000_0004.
- At pc=32'h8000_0000, jump with jump_index=26'h2D -> next pc=32'h8000_00B4; IF/ID bubbled (valid=0).
- Free-running at pc=32'h0000_0070 with irq=1 and ctrl_pending=0 -> next pc=32'h8000_0004, epc=32'h0000_0070, irq_ack pulses once. With pc[31]=1, irq is ignored.
- Same cycle: branch_taken=1 (target 32'h0000_0078), stall=1, irq=1 -> pc=32'h0000_0078, flush wins over stall, no irq_ack.
- exc=1 with exc_pc=32'h0000_0040, irq=1 -> pc=32'h8000_0008, epc=32'h0000_0044. Then jr to 32'h0000_0044 -> pc[31] clears, and irq is taken on the next eligible cycle.
- stall held 3 cycles -> pc and IF/ID unchanged. Assert reset mid-stall -> pc=32'h8000_0000 asynchronously and if_id_valid=0.
